data_mem_ctrl: RTL and testbench
================================

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 2: extra SRAM cycles after the access cycle, range 0..15.
REQ-002 SHALL have parameter ADDR_W, default 10: width of the SRAM word address.
REQ-003 SHALL have port clk  in  1: the single core clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  in  1: reset, synchronous, active-high.
REQ-005 SHALL have port req_read  in  1: core load request; connects to the core memoryRead.
REQ-006 SHALL have port req_write  in  1: core store request; connects to the core writeFlag.
REQ-007 SHALL have port req_addr  in  32: core byte address; connects to the core addressIn.
REQ-008 SHALL have port req_wdata  in  32: core store data; connects to the core dataOut.
REQ-009 SHALL have port rsp_rdata  out  32: load data; connects to the core memoryDataIn.
REQ-010 SHALL have port rsp_valid  out  1: one-cycle completion pulse for loads and stores.
REQ-011 SHALL have port busy  out  1: stall to the core; high whenever state is not IDLE.
REQ-012 SHALL have port err  out  2: sticky error flags; bit0 = read/write conflict, bit1 = misaligned access.
REQ-013 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 32, mem_rdata in 32: the SRAM side.

Function
REQ-014 SHALL implement the state machine IDLE, ACCESS, WAIT, RESP.
REQ-015 IDLE: if req_read or req_write is high, SHALL capture req_addr[ADDR_W+1:2], req_wdata and the op type, then go to ACCESS on the next cycle.
REQ-016 ACCESS: SHALL last exactly 1 cycle, with mem_en=1, mem_we=(op==write), mem_addr and mem_wdata driven from the captured values; next state is WAIT if WAIT_STATES>0, else RESP.
REQ-017 WAIT: SHALL last exactly WAIT_STATES cycles, counted down by a counter loaded in ACCESS; mem_en=0; then go to RESP.
REQ-018 For a load, rsp_rdata SHALL be loaded from mem_rdata on the edge that enters RESP; it SHALL hold that value until the next load completes.
REQ-019 For a store, rsp_rdata SHALL be left unchanged.
REQ-020 RESP: SHALL last 1 cycle with rsp_valid=1, then return to IDLE.
REQ-021 Latency from a request sampled in IDLE at edge k SHALL be: rsp_valid high in cycle k+2+WAIT_STATES.
REQ-022 Requests while busy=1 SHALL be ignored; the core holds its request until rsp_valid and deasserts it in the following cycle.
REQ-023 Back-to-back requests: a request present in the IDLE cycle directly after RESP SHALL be accepted as a new access.
REQ-024 If req_read and req_write are high together, the access SHALL be performed as a store and err[0] SHALL be set.
REQ-025 mem_en and mem_we SHALL be 0 in every state except ACCESS.
REQ-026 err bits SHALL be set-only; they clear only on reset.

Reset
REQ-027 When rst is high at a clock edge: state=IDLE, counter=0, rsp_rdata=0, rsp_valid=0, busy=0, err=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-028 Reset during ACCESS, WAIT or RESP SHALL abort the access with no rsp_valid; a request present in the first cycle after reset SHALL be accepted normally.

Configuration
REQ-029 Macro DMEM_ALIGN_CHECK_EN defined: a request with req_addr[1:0]!=0 SHALL skip ACCESS and WAIT and go IDLE to RESP; no SRAM access occurs, rsp_rdata=0 for a load, and err[1] is set.
REQ-030 Macro DMEM_ALIGN_CHECK_EN undefined: req_addr[1:0] SHALL be ignored and err[1] SHALL be tied to 0.

Structure
REQ-031 Shared package dmem_pkg SHALL hold the state encoding (IDLE=0, ACCESS=1, WAIT=2, RESP=3), the err bit index constants ERR_CONFLICT=0 and ERR_MISALIGN=1, and the op-type encoding.
REQ-032 One sub-module dmem_wait_cnt (loadable 4-bit down-counter with a zero flag) SHALL be used for the WAIT state; everything else lives in data_mem_ctrl.

Verification
REQ-033 Load, WAIT_STATES=2, req_addr=0x10, SRAM word 4 = 0xDEADBEEF -> mem_en in cycle k+1 with mem_addr=4; rsp_valid in cycle k+4; rsp_rdata=0xDEADBEEF.
REQ-034 Store, WAIT_STATES=0, req_addr=0x8, req_wdata=0x12345678 -> mem_we=1 with mem_addr=2 in cycle k+1; rsp_valid in cycle k+2; a following load from 0x8 returns 0x12345678.
REQ-035 req_read=req_write=1 at 0x4 -> a store is performed and err=2'b01 persists until rst.
REQ-036 rst asserted during WAIT -> next cycle state=IDLE, busy=0, no rsp_valid, err=0.
REQ-037 DMEM_ALIGN_CHECK_EN defined, load at 0x6 -> mem_en never asserted; rsp_valid in cycle k+1; rsp_rdata=0; err[1]=1. Macro undefined, same stimulus -> normal access to mem_addr=1; err=0.
REQ-038 Request held through busy, then a second request in the IDLE cycle after RESP -> exactly two SRAM accesses and two rsp_valid pulses.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: FSM states, op type, error bit indices.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } dmemState_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } dmemOp_t;

    localparam int unsigned ERR_CONFLICT = 0;
    localparam int unsigned ERR_MISALIGN = 1;

    // WAIT exits on the zero flag, so the counter is preloaded with one less than the wait count.
    function automatic logic [3:0] waitLoadValue(input int unsigned waitStates);
        return (waitStates == 0) ? 4'd0 : 4'(waitStates - 1);
    endfunction

endpackage

// File: rtl/dmem_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag, used to time the SRAM wait states.
module dmem_wait_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    input  logic [3:0] loadVal,
    output logic [3:0] count,
    output logic       zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (dec && (count != '0)) begin
            count <= count - 4'd1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/data_mem_ctrl.sv
// Core-to-SRAM data memory controller: IDLE/ACCESS/WAIT/RESP with configurable wait states.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses without touching the SRAM.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_valid,
    output logic              busy,
    output logic [1:0]        err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    dmemState_t        state, nextState;
    dmemOp_t           opReg;
    logic [ADDR_W-1:0] addrReg;
    logic [31:0]       wdataReg;
    logic [31:0]       rdataReg;
    logic [1:0]        errReg;
    logic              accept;
    logic              misaligned;
    logic              cntLoad, cntDec, cntZero;
    logic [3:0]        cntValue;
    logic              unusedAddrBits;

    assign accept = (state == IDLE) && (req_read || req_write);

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (req_addr[1:0] != 2'b00);
    assign err        = errReg;
`else
    assign misaligned = 1'b0;
    assign err        = {1'b0, errReg[ERR_CONFLICT]};
`endif
    assign unusedAddrBits = ^{req_addr[31:ADDR_W+2], req_addr[1:0], cntValue};

    dmem_wait_cnt waitCnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cntLoad),
        .dec     (cntDec),
        .loadVal (waitLoadValue(WAIT_STATES)),
        .count   (cntValue),
        .zero    (cntZero)
    );

    always_comb begin
        nextState = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cntLoad   = 1'b0;
        cntDec    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) nextState = misaligned ? RESP : ACCESS;
            end
            ACCESS: begin
                mem_en    = 1'b1;
                mem_we    = (opReg == OP_WRITE);
                cntLoad   = 1'b1;
                nextState = (WAIT_STATES > 0) ? WAIT : RESP;
            end
            WAIT: begin
                cntDec = 1'b1;
                if (cntZero) nextState = RESP;
            end
            RESP: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            opReg    <= OP_READ;
            addrReg  <= '0;
            wdataReg <= '0;
            rdataReg <= '0;
            errReg   <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                addrReg  <= req_addr[ADDR_W+1:2];
                wdataReg <= req_wdata;
                opReg    <= req_write ? OP_WRITE : OP_READ;
                if (req_read && req_write) errReg[ERR_CONFLICT] <= 1'b1;
                if (misaligned) begin
                    errReg[ERR_MISALIGN] <= 1'b1;
                    if (!req_write) rdataReg <= '0;
                end
            end
            // Load data is captured only on the edge leaving ACCESS/WAIT into RESP.
            if ((state != IDLE) && (nextState == RESP) && (opReg == OP_READ)) begin
                rdataReg <= mem_rdata;
            end
        end
    end

    assign rsp_rdata = rdataReg;
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign mem_addr  = addrReg;
    assign mem_wdata = wdataReg;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: random loads/stores checked against a word-array reference model.
module tb_data_mem_ctrl;

    localparam int WS = 2;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_read, req_write;
    logic [31:0]   req_addr, req_wdata;
    logic [31:0]   rsp_rdata;
    logic          rsp_valid, busy;
    logic [1:0]    err;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    data_mem_ctrl #(.WAIT_STATES(WS), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_rdata(rsp_rdata), .rsp_valid(rsp_valid),
        .busy(busy), .err(err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // SRAM seen by the DUT: asynchronous read, synchronous write.
    logic [31:0] sram [0:(1<<AW)-1];
    assign mem_rdata = sram[mem_addr];
    always @(posedge clk) if (mem_en && mem_we) sram[mem_addr] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [AW-1:0] addr; logic we; logic [31:0] wdata; } acc_t;
    typedef struct { logic [31:0] rdata; logic [1:0] err; int vcyc; } rsp_t;
    acc_t accQ[$];
    rsp_t rspQ[$];

    logic [31:0] refMem [0:(1<<AW)-1];
    logic [31:0] refRdata;
    logic [1:0]  refErr;
    int nCmp = 0, nBad = 0, respSeen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    acc_t monAcc;
    rsp_t monRsp;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (accQ.size() == 0) begin
                    nCmp++; nBad++;
                    $display("FAIL sramAccess: unexpected mem_en addr %h (cycle %0d)", mem_addr, cyc);
                end else begin
                    monAcc = accQ.pop_front();
                    check("memAddr", 32'(mem_addr), 32'(monAcc.addr));
                    check("memWe", 32'(mem_we), 32'(monAcc.we));
                    if (monAcc.we) check("memWdata", mem_wdata, monAcc.wdata);
                end
            end else if (mem_we) begin
                nCmp++; nBad++;
                $display("FAIL memWeIdle: got 1 expected 0 (cycle %0d)", cyc);
            end
            if (rsp_valid) begin
                respSeen++;
                if (rspQ.size() == 0) begin
                    nCmp++; nBad++;
                    $display("FAIL rspValid: unexpected pulse, got 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    monRsp = rspQ.pop_front();
                    check("rspRdata", rsp_rdata, monRsp.rdata);
                    check("rspErr", 32'(err), 32'(monRsp.err));
                    check("rspCycle", cyc, monRsp.vcyc);
                end
            end
        end
    end

    // Issue one request (from an IDLE cycle, or directly in the RESP cycle when b2b), hold until rsp_valid.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit b2b);
        logic [AW-1:0] word;
        logic          mis;
        int            k, start;
        acc_t          a;
        rsp_t          r;
        word = addr[AW+1:2];
        mis  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`endif
        k = b2b ? cyc + 2 : cyc + 1;
        if (rd && wr) refErr[0] = 1'b1;
        if (mis) begin
            refErr[1] = 1'b1;
            if (!wr) refRdata = '0;
            r.vcyc = k;
        end else begin
            a.addr = word; a.we = wr; a.wdata = wdata;
            accQ.push_back(a);
            if (wr) refMem[word] = wdata;
            else    refRdata = refMem[word];
            r.vcyc = k + 1 + WS;
        end
        r.rdata = refRdata;
        r.err   = refErr;
        rspQ.push_back(r);
        req_read = rd; req_write = wr; req_addr = addr; req_wdata = wdata;
        start = respSeen;
        for (int i = 0; i < 60 && respSeen == start; i++) begin
            @(negedge clk); #2;
        end
        if (respSeen == start) begin
            nCmp++; nBad++;
            $display("FAIL rspTimeout: got no rsp_valid expected one for addr %h", addr);
            rspQ.delete(); accQ.delete();
        end
    endtask

    task automatic idle(input int n);
        req_read = 1'b0; req_write = 1'b0;
        repeat (n + 1) begin @(negedge clk); #2; end
    endtask

    logic rd, wr, lastB2b;
    logic [31:0] ad;
    int sel;

    initial begin
        rst = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = $urandom; refMem[i] = sram[i];
        end
        sram[4] = 32'hDEADBEEF; refMem[4] = 32'hDEADBEEF;
        refRdata = '0; refErr = '0;
        repeat (3) @(negedge clk);
        #2;
        check("rstBusy", 32'(busy), 0);
        check("rstValid", 32'(rsp_valid), 0);
        check("rstErr", 32'(err), 0);
        check("rstRdata", rsp_rdata, 0);
        check("rstMemEn", 32'(mem_en), 0);
        check("rstMemWe", 32'(mem_we), 0);
        check("rstMemAddr", 32'(mem_addr), 0);
        check("rstMemWdata", mem_wdata, 0);
        rst = 1'b0;

        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        idle(1);
        issue(1'b0, 1'b1, 32'h8, 32'h12345678, 1'b0);
        issue(1'b1, 1'b0, 32'h8, 32'h0, 1'b1);
        idle(0);
        issue(1'b1, 1'b0, 32'h6, 32'h0, 1'b0);
        idle(2);
        issue(1'b1, 1'b1, 32'h4, 32'hCAFEF00D, 1'b0);
        idle(3);
        check("errSticky", 32'(err), 32'(refErr));

        lastB2b = 1'b0;
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 9);
            rd = (sel == 0) || (sel > 4);
            wr = (sel <= 4);
            ad = {22'd0, 6'($urandom_range(0, 63)), 2'b00} + 32'(($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0);
            lastB2b = (t > 0) && ($urandom_range(0, 1) == 1);
            if (!lastB2b) idle($urandom_range(0, 3));
            issue(rd, wr, ad, $urandom, lastB2b);
        end
        idle(2);
        check("errFinal", 32'(err), 32'(refErr));

        // Abort a load in WAIT with reset; nothing of it may surface afterwards.
        issue_abort();
        idle(4);
        check("accQDrained", 32'(accQ.size()), 0);
        check("rspQDrained", 32'(rspQ.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

    task automatic issue_abort();
        acc_t a;
        a.addr = 10'd8; a.we = 1'b0; a.wdata = '0;
        accQ.push_back(a);
        req_read = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_wdata = '0;
        @(negedge clk); #2;
        req_read = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        @(negedge clk); #2;
        check("abortBusy", 32'(busy), 0);
        check("abortValid", 32'(rsp_valid), 0);
        check("abortErr", 32'(err), 0);
        check("abortRdata", rsp_rdata, 0);
        refErr = '0; refRdata = '0;
        rst = 1'b0;
        issue(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    endtask

endmodule
